// File: rtl/lpc_pkg.sv
// Shared state encoding, cycle-type and SYNC codes for the LPC cycle decoder.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CYCTYPE = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WDATA   = 3'd3,
        ST_TAR     = 3'd4,
        ST_SYNC    = 3'd5,
        ST_RDATA   = 3'd6
    } lpc_state_e;

    localparam logic [1:0] CT_IO  = 2'b00;
    localparam logic [1:0] CT_MEM = 2'b01;

    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_SHORT = 4'h5;
    localparam logic [3:0] SYNC_LONG  = 4'h6;
    localparam logic [3:0] SYNC_ERR   = 4'hA;

    localparam logic [3:0] START_TGT = 4'h0;
    localparam logic [3:0] ABORT     = 4'hF;

    localparam int IO_NIBBLES  = 4;
    localparam int MEM_NIBBLES = 8;

    function automatic logic is_wait_sync(input logic [3:0] nib);
        return (nib == SYNC_SHORT) || (nib == SYNC_LONG);
    endfunction

    function automatic logic is_done_sync(input logic [3:0] nib);
        return (nib == SYNC_READY) || (nib == SYNC_ERR);
    endfunction

endpackage

// File: rtl/lpc_cycle_decoder.sv
// LPC I/O and memory cycle decoder producing one record pulse per completed cycle.
// Optional START timestamp capture is enabled by defining LPC_TIMESTAMP_EN.
module lpc_cycle_decoder
    import lpc_pkg::*;
#(
    parameter int WAIT_LIMIT  = 255,
    parameter int CAPTURE_IO  = 1,
    parameter int CAPTURE_MEM = 1,
    parameter int TS_W        = 16
) (
    input  logic            lpc_clock,
    input  logic            lpc_reset,
    input  logic [3:0]      lpc_ad,
    input  logic            lpc_frame,
    output logic            rec_valid,
    output logic            rec_mem,
    output logic            rec_write,
    output logic [31:0]     rec_addr,
    output logic [7:0]      rec_data,
    output logic            rec_err,
    output logic            rec_timeout,
    output logic [TS_W-1:0] rec_time,
    output logic            busy,
    output logic [7:0]      abort_count
);

    localparam logic [15:0] WAIT_MAX = 16'(WAIT_LIMIT);
    localparam logic [2:0]  IO_LAST  = 3'(IO_NIBBLES - 1);
    localparam logic [2:0]  MEM_LAST = 3'(MEM_NIBBLES - 1);

    lpc_state_e  state_q, state_d;
    logic [2:0]  nib_q, nib_d;
    logic [15:0] wait_q, wait_d;
    logic        mem_q, mem_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        err_q, err_d;

    logic        start;
    logic        emit;
    logic        emit_timeout;
    logic        abort_inc;
    logic        capture_en;
    logic        rec_valid_d;

    logic        rec_valid_q;
    logic        rec_mem_q;
    logic        rec_write_q;
    logic [31:0] rec_addr_q;
    logic [7:0]  rec_data_q;
    logic        rec_err_q;
    logic        rec_timeout_q;
    logic [7:0]  abort_q;

    always_comb begin
        state_d      = state_q;
        nib_d        = nib_q;
        wait_d       = wait_q;
        mem_d        = mem_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_d        = err_q;
        start        = 1'b0;
        emit         = 1'b0;
        emit_timeout = 1'b0;
        abort_inc    = 1'b0;

        if (!lpc_frame) begin
            // A repeated START while still in CYCTYPE just moves the START point.
            case (lpc_ad)
                START_TGT: begin
                    start     = 1'b1;
                    state_d   = ST_CYCTYPE;
                    nib_d     = '0;
                    wait_d    = '0;
                    mem_d     = 1'b0;
                    write_d   = 1'b0;
                    addr_d    = '0;
                    data_d    = '0;
                    err_d     = 1'b0;
                    abort_inc = (state_q != ST_IDLE) && (state_q != ST_CYCTYPE);
                end
                ABORT: begin
                    if (state_q != ST_IDLE) begin
                        state_d   = ST_IDLE;
                        abort_inc = 1'b1;
                    end
                end
                default: begin
                    if (state_q != ST_IDLE) begin
                        state_d   = ST_IDLE;
                        abort_inc = 1'b1;
                    end
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CYCTYPE: begin
                    write_d = lpc_ad[1];
                    nib_d   = '0;
                    if (lpc_ad[3:2] == CT_IO) begin
                        mem_d   = 1'b0;
                        state_d = ST_ADDR;
                    end else if (lpc_ad[3:2] == CT_MEM) begin
                        mem_d   = 1'b1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d   = ST_IDLE;
                        abort_inc = 1'b1;
                    end
                end
                ST_ADDR: begin
                    addr_d = {addr_q[27:0], lpc_ad};
                    nib_d  = nib_q + 3'd1;
                    if (nib_q == (mem_q ? MEM_LAST : IO_LAST)) begin
                        nib_d   = '0;
                        state_d = write_q ? ST_WDATA : ST_TAR;
                    end
                end
                ST_WDATA: begin
                    if (nib_q == 3'd0) begin
                        data_d[3:0] = lpc_ad;
                        nib_d       = 3'd1;
                    end else begin
                        data_d[7:4] = lpc_ad;
                        nib_d       = '0;
                        state_d     = ST_TAR;
                    end
                end
                ST_TAR: begin
                    if (nib_q == 3'd0) begin
                        nib_d = 3'd1;
                    end else begin
                        nib_d   = '0;
                        wait_d  = '0;
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (is_done_sync(lpc_ad)) begin
                        if (lpc_ad == SYNC_ERR) begin
                            err_d = 1'b1;
                        end
                        if (write_q) begin
                            emit    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            nib_d   = '0;
                            state_d = ST_RDATA;
                        end
                    end else if (is_wait_sync(lpc_ad)) begin
                        if (wait_q == WAIT_MAX) begin
                            emit         = 1'b1;
                            emit_timeout = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            wait_d = wait_q + 16'd1;
                        end
                    end else begin
                        state_d   = ST_IDLE;
                        abort_inc = 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (nib_q == 3'd0) begin
                        data_d[3:0] = lpc_ad;
                        nib_d       = 3'd1;
                    end else begin
                        data_d[7:4] = lpc_ad;
                        nib_d       = '0;
                        emit        = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Filtered cycles run through the FSM but never disturb the held record.
    assign capture_en  = mem_q ? (CAPTURE_MEM != 0) : (CAPTURE_IO != 0);
    assign rec_valid_d = emit && capture_en;

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q <= ST_IDLE;
            nib_q   <= '0;
            wait_q  <= '0;
            mem_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            wait_q  <= wait_d;
            mem_q   <= mem_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            rec_valid_q   <= 1'b0;
            rec_mem_q     <= 1'b0;
            rec_write_q   <= 1'b0;
            rec_addr_q    <= '0;
            rec_data_q    <= '0;
            rec_err_q     <= 1'b0;
            rec_timeout_q <= 1'b0;
            abort_q       <= '0;
        end else begin
            rec_valid_q <= rec_valid_d;
            if (rec_valid_d) begin
                rec_mem_q     <= mem_q;
                rec_write_q   <= write_q;
                rec_addr_q    <= addr_d;
                rec_data_q    <= emit_timeout ? 8'h00 : data_d;
                rec_err_q     <= err_d;
                rec_timeout_q <= emit_timeout;
            end
            if (abort_inc && (abort_q != 8'hFF)) begin
                abort_q <= abort_q + 8'd1;
            end
        end
    end

`ifdef LPC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] start_ts_q;
    logic [TS_W-1:0] rec_time_q;

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            ts_q       <= '0;
            start_ts_q <= '0;
            rec_time_q <= '0;
        end else begin
            ts_q <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
            if (start) begin
                start_ts_q <= ts_q;
            end
            if (rec_valid_d) begin
                rec_time_q <= start_ts_q;
            end
        end
    end

    assign rec_time = rec_time_q;
`else
    assign rec_time = '0;
`endif

    assign rec_valid   = rec_valid_q;
    assign rec_mem     = rec_mem_q;
    assign rec_write   = rec_write_q;
    assign rec_addr    = rec_addr_q;
    assign rec_data    = rec_data_q;
    assign rec_err     = rec_err_q;
    assign rec_timeout = rec_timeout_q;
    assign busy        = (state_q != ST_IDLE);
    assign abort_count = abort_q;

endmodule
